missile_fire_ctrl: RTL

//  Upstream of the missile mover: turns the raw shoot key into a single-cycle fire request.
//  One request per press. One missile in flight at a time.

---
 rtl/battle_pkg.sv | 24 ++
 rtl/frame_counter.sv | 33 +++
 rtl/missile_fire_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/battle_pkg.sv
// Shared types for the tank/missile blocks: fire-control states, headings and counter sizing.
// Used by missile_fire_ctrl (optional macro MISSILE_AUTO_FIRE_EN) and frame_counter.
package battle_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        FLIGHT   = 2'd2,
        COOLDOWN = 2'd3
    } fire_state_t;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    // Bits needed to hold the values 0..n.
    function automatic int counter_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Counts enable pulses (startOfFrame qualified by the caller) up to N, pulsing done on the Nth.
// clear wins over enable and holds the count at zero.
module frame_counter
    import battle_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int W = counter_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    // done is combinational so the owner reacts on the same edge that wraps the count.
    assign done = enable && !clear && (count == LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/missile_fire_ctrl.sv
// Turns the raw shoot key into one-cycle fire requests with cooldown, flight tracking and reloading ammo.
// Optional macro MISSILE_AUTO_FIRE_EN: a held key re-fires every time the controller returns to IDLE.
module missile_fire_ctrl
    import battle_pkg::*;
#(
    parameter int MAX_AMMO        = 3,
    parameter int RELOAD_FRAMES   = 60,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int FLIGHT_TIMEOUT  = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       fireKey,
    input  logic [1:0] tankDir,
    input  logic       missileActive,
    output logic       fireReq,
    output logic [1:0] shotDir,
    output logic [3:0] ammoCount,
    output logic       ready,
    output logic [1:0] stateDbg
);

    localparam logic [3:0] AMMO_FULL = 4'(MAX_AMMO);

    fire_state_t state;
    logic        seenActive;
    logic        keyMeta;
    logic        keySync;
    logic        keySync_d;
    logic        keyEdge;
    logic        trigger;
    logic        fireGo;
    logic        cdDone;
    logic        toDone;
    logic        rlDone;

    // Two-flop synchroniser for the asynchronous key, plus one more flop for the rising-edge detect.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            keyMeta   <= 1'b0;
            keySync   <= 1'b0;
            keySync_d <= 1'b0;
        end else begin
            keyMeta   <= fireKey;
            keySync   <= keyMeta;
            keySync_d <= keySync;
        end
    end

    assign keyEdge = keySync & ~keySync_d;

`ifdef MISSILE_AUTO_FIRE_EN
    assign trigger = keyEdge | keySync;
`else
    assign trigger = keyEdge;
`endif

    // Presses outside IDLE, or with no ammo or a missile still drawn, are simply dropped.
    assign fireGo = (state == IDLE) && trigger && (ammoCount != 4'd0) && !missileActive;

    frame_counter #(.N(COOLDOWN_FRAMES)) u_cooldown (
        .clk    (clk),
        .resetN (resetN),
        .clear  (state != COOLDOWN),
        .enable (startOfFrame && (state == COOLDOWN)),
        .done   (cdDone)
    );

    frame_counter #(.N(FLIGHT_TIMEOUT)) u_flight_timeout (
        .clk    (clk),
        .resetN (resetN),
        .clear  ((state != FLIGHT) || seenActive),
        .enable (startOfFrame && (state == FLIGHT)),
        .done   (toDone)
    );

    // The reload counter is parked at zero whenever the magazine is full.
    frame_counter #(.N(RELOAD_FRAMES)) u_reload (
        .clk    (clk),
        .resetN (resetN),
        .clear  (ammoCount >= AMMO_FULL),
        .enable (startOfFrame),
        .done   (rlDone)
    );

    // fireReq is a bare one-cycle strobe with no ready: the mover acknowledges only through missileActive.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            fireReq    <= 1'b0;
            shotDir    <= DIR_UP;
            ammoCount  <= AMMO_FULL;
            seenActive <= 1'b0;
        end else begin
            fireReq <= 1'b0;
            case (state)
                IDLE: begin
                    if (fireGo) begin
                        state   <= FIRE;
                        fireReq <= 1'b1;
                        shotDir <= tankDir;
                    end
                end
                FIRE: begin
                    state      <= FLIGHT;
                    seenActive <= 1'b0;
                end
                FLIGHT: begin
                    if (missileActive) begin
                        seenActive <= 1'b1;
                    end
                    if (seenActive && !missileActive) begin
                        state <= COOLDOWN;
                    end else if (!seenActive && !missileActive && toDone) begin
                        state <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cdDone) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A reload landing on the same edge as a shot cancels out.
            if (fireGo && !rlDone) begin
                ammoCount <= ammoCount - 1'b1;
            end else if (!fireGo && rlDone && (ammoCount < AMMO_FULL)) begin
                ammoCount <= ammoCount + 1'b1;
            end
        end
    end

    assign ready    = (state == IDLE) && (ammoCount != 4'd0);
    assign stateDbg = state;

endmodule
